// File: rtl/fpmul_ctrl_pkg.sv
// Shared definitions for the floating-point multiplier request controller:
// FSM state encoding and default parameter values.
package fpmul_ctrl_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/fpmul_ctrl_rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie the requester that was not granted
// last wins; the last-grant pointer moves only when the owner finishes.
module rr_arbiter2
  import fpmul_ctrl_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_update,
  input  logic       i_winner,
  output logic [1:0] o_grant
);

  logic r_last;

  always_comb begin
    o_grant = i_req;
    if (i_req == 2'b11) o_grant = r_last ? 2'b01 : 2'b10;
  end

  // Pointer starts at 1 so requester 0 wins the first tie.
  always_ff @(posedge i_clk) begin
    if (i_rst)         r_last <= 1'b1;
    else if (i_update) r_last <= i_winner;
  end

endmodule

// File: rtl/fpmul_ctrl.sv
// Controller that arbitrates two requesters onto one external FP multiplier
// core, issues a start pulse, waits for done with a timeout, and returns the result.
module fpmul_ctrl
  import fpmul_ctrl_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*DATA_W-1:0] req_a,
  input  logic [2*DATA_W-1:0] req_b,
  output logic [1:0]          rsp_valid,
  input  logic [1:0]          rsp_ready,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_err,
  output logic                core_start,
  output logic [DATA_W-1:0]   core_a,
  output logic [DATA_W-1:0]   core_b,
  input  logic                core_done,
  input  logic [DATA_W-1:0]   core_result,
  output logic                busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_id;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_err;

  logic [1:0]        w_grant;
  logic              w_win;
  logic              w_accept;
  logic              w_rsp_done;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_tmo;

  rr_arbiter2 u_arb (
    .i_clk    (ACLK),
    .i_rst    (ARESET),
    .i_req    (req_valid),
    .i_update (w_rsp_done),
    .i_winner (r_id),
    .o_grant  (w_grant)
  );

  assign w_win      = w_grant[1];
  assign req_ready  = (!ARESET && r_state == ST_IDLE) ? w_grant : 2'b00;
  assign w_accept   = |req_ready;
  assign w_rsp_done = (r_state == ST_RESP) && rsp_ready[r_id];
  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_tmo      = (w_cnt_inc == CNT_W'(TIMEOUT));

  // Every output is forced low while reset is held, not just after the edge.
  assign core_start = !ARESET && (r_state == ST_ISSUE);
  assign busy       = !ARESET && (r_state != ST_IDLE);
  assign rsp_valid  = (!ARESET && r_state == ST_RESP) ? (r_id ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_data   = ARESET ? '0 : r_rsp_data;
  assign rsp_err    = !ARESET && r_rsp_err;
  assign core_a     = ARESET ? '0 : r_a;
  assign core_b     = ARESET ? '0 : r_b;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = ST_ISSUE;
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT:  if (core_done || w_tmo) w_state_nxt = ST_RESP;
      ST_RESP:  if (w_rsp_done) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state    <= ST_IDLE;
      r_id       <= 1'b0;
      r_cnt      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      unique case (r_state)
        ST_IDLE: if (w_accept) begin
          r_id <= w_win;
          r_a  <= w_win ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
          r_b  <= w_win ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
        end
        ST_ISSUE: r_cnt <= '0;
        // A done arriving on the timeout cycle takes priority over the abort.
        ST_WAIT: begin
          if (core_done) begin
            r_rsp_data <= core_result;
            r_rsp_err  <= 1'b0;
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_tmo) begin
              r_rsp_data <= '0;
              r_rsp_err  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
